bc_scorer: RTL and testbench



---
 rtl/bc_pkg.sv | 29 ++
 rtl/bc_code_check.sv | 34 +++
 rtl/bc_scorer.sv | 194 +++++++++++++++++++
 tb/tb_bc_scorer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// -----------------------------------------------------------------------------
// bc_pkg -- shared types and constants for the Bulls & Cows datapath.
//
// Holds the code geometry (DIGITS digits of DW bits each), the digit and code
// types shared with the game-control FSM, and the scorer state encoding.
// A code packs digit k at bits [DW*k+DW-1 : DW*k], which is exactly the
// layout of the packed array code_t, so code[k] selects digit k.
// -----------------------------------------------------------------------------
package bc_pkg;

  localparam int DIGITS = 4;                    // digits per code
  localparam int DW     = 4;                    // bits per digit (BCD nibble)
  localparam int CW     = $clog2(DIGITS + 1);   // width of bulls/cows counts
  localparam int IW     = $clog2(DIGITS);       // width of the digit index

  typedef logic [DW-1:0] digit_t;
  typedef digit_t [DIGITS-1:0] code_t;
  typedef logic [CW-1:0] count_t;

  localparam digit_t DIGIT_MAX = digit_t'(9);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALIDATE = 2'd1,
    COMPARE  = 2'd2,
    DONE     = 2'd3
  } scorer_state_t;

endpackage : bc_pkg

// File: rtl/bc_code_check.sv
// -----------------------------------------------------------------------------
// bc_code_check -- combinational legality check of one code.
//
// A code is legal when every digit is a decimal digit (<= DIGIT_MAX) and no
// two digits are equal.
//
// Ports:
//   code   in   code_t   code under test
//   legal  out  1        1 = all digits in range and pairwise distinct
// -----------------------------------------------------------------------------
module bc_code_check
  import bc_pkg::*;
(
  input  code_t code,
  output logic  legal
);

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path can leave it unassigned and infer a latch.
    legal = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (code[i] > DIGIT_MAX) begin
        legal = 1'b0;
      end
      for (int j = i + 1; j < DIGITS; j++) begin
        if (code[i] == code[j]) begin
          legal = 1'b0;
        end
      end
    end
  end

endmodule : bc_code_check

// File: rtl/bc_scorer.sv
// -----------------------------------------------------------------------------
// bc_scorer -- Bulls & Cows scoring stage.
//
// Accepts a secret/guess pair over a valid/ready handshake, validates the
// guess (decimal digits, all distinct), then scores it serially, one guess
// digit per cycle, and presents bulls/cows/win/invalid plus the player tag
// until the consumer takes it.
//
// Sequence: IDLE -> VALIDATE -> COMPARE (DIGITS cycles) -> DONE -> IDLE.
// An illegal pair skips COMPARE and goes straight to DONE with invalid set.
//
// Optional build macro:
//   BC_SECRET_CHECK_EN  when defined, the latched secret is validated with the
//                       same rules as the guess; a bad secret reports invalid.
//                       When undefined, the secret is trusted as-is.
//
// Ports:
//   clock        in   1          system clock, rising edge
//   reset        in   1          synchronous, active-high reset
//   in_valid     in   1          secret/guess pair presented
//   in_ready     out  1          scorer idle, pair accepted when in_valid
//   in_player    in   1          player tag (0 = J1, 1 = J2)
//   in_secret    in   DIGITS*DW  secret code
//   in_guess     in   DIGITS*DW  guess code, same packing
//   out_valid    out  1          result available
//   out_ready    in   1          consumer takes result
//   out_bulls    out  CW         digits matching in value and position
//   out_cows     out  CW         digits present in secret at another position
//   out_win      out  1          legal guess with bulls == DIGITS
//   out_invalid  out  1          pair rejected, counts forced to 0
//   out_player   out  1          latched player tag
// -----------------------------------------------------------------------------
module bc_scorer
  import bc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_player,
  input  logic [DIGITS*DW-1:0] in_secret,
  input  logic [DIGITS*DW-1:0] in_guess,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_bulls,
  output logic [CW-1:0]        out_cows,
  output logic                 out_win,
  output logic                 out_invalid,
  output logic                 out_player
);

  scorer_state_t state_q, state_d;

  code_t         secret_q;
  code_t         guess_q;
  logic          player_q;
  logic [IW-1:0] idx_q;
  count_t        bulls_q;
  count_t        cows_q;
  logic          invalid_q;

  logic          accept;
  logic          last_digit;
  logic          guess_legal;
  logic          secret_legal;
  logic          pair_legal;
  digit_t        cur_guess;
  logic          is_bull;
  logic          is_cow;

  // ---------------------------------------------------------------------------
  // Legality checks on the latched codes
  // ---------------------------------------------------------------------------
  bc_code_check u_guess_check (
    .code  (guess_q),
    .legal (guess_legal)
  );

`ifdef BC_SECRET_CHECK_EN
  bc_code_check u_secret_check (
    .code  (secret_q),
    .legal (secret_legal)
  );
`else
  assign secret_legal = 1'b1;
`endif

  assign pair_legal = guess_legal && secret_legal;

  // ---------------------------------------------------------------------------
  // Per-digit scoring of guess digit idx_q. A bull takes priority over a cow,
  // so each digit contributes at most one increment and bulls + cows <= DIGITS
  // even if the secret is malformed.
  // ---------------------------------------------------------------------------
  assign cur_guess = guess_q[idx_q];
  assign is_bull   = (cur_guess == secret_q[idx_q]);

  always_comb begin
    is_cow = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((IW'(j) != idx_q) && (secret_q[j] == cur_guess)) begin
        is_cow = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid && in_ready;
  assign last_digit = (idx_q == IW'(DIGITS - 1));

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept)     state_d = VALIDATE;
      VALIDATE: state_d = pair_legal ? COMPARE : DONE;
      COMPARE:  if (last_digit) state_d = DONE;
      DONE:     if (out_ready)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand latch. Captured only on acceptance and never read before then.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: pure data registers carry no reset; they are always written on
    // acceptance before VALIDATE reads them, so reset would only cost routing.
    if (accept) begin
      secret_q <= in_secret;
      guess_q  <= in_guess;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, index and result flags. Held unchanged in DONE so the result is
  // stable for as long as the consumer stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      player_q  <= 1'b0;
      idx_q     <= '0;
      bulls_q   <= '0;
      cows_q    <= '0;
      invalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            player_q <= in_player;
          end
        end
        VALIDATE: begin
          idx_q     <= '0;
          bulls_q   <= '0;
          cows_q    <= '0;
          invalid_q <= !pair_legal;
        end
        COMPARE: begin
          idx_q <= idx_q + IW'(1);
          if (is_bull) begin
            bulls_q <= bulls_q + CW'(1);
          end else if (is_cow) begin
            cows_q <= cows_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result outputs
  // ---------------------------------------------------------------------------
  assign out_bulls   = bulls_q;
  assign out_cows    = cows_q;
  assign out_invalid = invalid_q;
  assign out_player  = player_q;
  assign out_win     = !invalid_q && (bulls_q == CW'(DIGITS));

endmodule : bc_scorer

// File: tb/tb_bc_scorer.sv
// -----------------------------------------------------------------------------
// tb_bc_scorer -- self-checking bench for bc_scorer.
//
// Directed vectors from a table, hand-written sequences for back-pressure and
// reset abort, and random pairs scored by a behavioural model of the game
// rules. Latency is counted in rising edges from the acceptance edge (edge 0)
// to the edge at which the consumer first samples out_valid high.
// -----------------------------------------------------------------------------
module tb_bc_scorer;
  import bc_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_player;
  logic [DIGITS*DW-1:0] in_secret;
  logic [DIGITS*DW-1:0] in_guess;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_bulls;
  logic [CW-1:0]        out_cows;
  logic                 out_win;
  logic                 out_invalid;
  logic                 out_player;

  int passed = 0;
  int total  = 0;

  bc_scorer dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_player   (in_player),
    .in_secret   (in_secret),
    .in_guess    (in_guess),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bulls   (out_bulls),
    .out_cows    (out_cows),
    .out_win     (out_win),
    .out_invalid (out_invalid),
    .out_player  (out_player)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] secret;
    logic [15:0] guess;
    logic        player;
    int          bulls;
    int          cows;
    int          win;
    int          invalid;
    int          lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: game rules applied to plain digit arrays.
  // ---------------------------------------------------------------------------
  function automatic bit code_ok(input logic [15:0] c);
    int d[4];
    for (int i = 0; i < 4; i++) d[i] = int'(c[4*i +: 4]);
    for (int i = 0; i < 4; i++) begin
      if (d[i] > 9) return 1'b0;
      for (int j = 0; j < i; j++) if (d[i] == d[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model(input logic [15:0] s, input logic [15:0] g,
                                output int b, output int c, output int w,
                                output int inv, output int lat);
    int sd[4];
    int gd[4];
    bit found;
    for (int i = 0; i < 4; i++) begin
      sd[i] = int'(s[4*i +: 4]);
      gd[i] = int'(g[4*i +: 4]);
    end
    inv = code_ok(g) ? 0 : 1;
`ifdef BC_SECRET_CHECK_EN
    if (!code_ok(s)) inv = 1;
`endif
    b = 0;
    c = 0;
    if (inv == 1) begin
      lat = 2;
    end else begin
      lat = 4 + 2;
      for (int i = 0; i < 4; i++) begin
        if (gd[i] == sd[i]) begin
          b++;
        end else begin
          found = 1'b0;
          for (int j = 0; j < 4; j++) if (j != i && sd[j] == gd[i]) found = 1'b1;
          if (found) c++;
        end
      end
    end
    w = (inv == 0 && b == 4) ? 1 : 0;
  endfunction

  function automatic logic [15:0] rand_legal();
    logic [15:0] r;
    int d[4];
    bit dup;
    for (int i = 0; i < 4; i++) begin
      do begin
        d[i] = int'($urandom_range(0, 9));
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (d[j] == d[i]) dup = 1'b1;
      end while (dup);
      r[4*i +: 4] = 4'(d[i]);
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_guess(input logic [15:0] s);
    logic [15:0] g;
    logic [3:0]  t;
    int          k;
    case ($urandom_range(0, 3))
      0: begin
        g = s;
        for (int i = 3; i > 0; i--) begin
          k = int'($urandom_range(0, i));
          t = g[4*i +: 4];
          g[4*i +: 4] = g[4*k +: 4];
          g[4*k +: 4] = t;
        end
      end
      1: g = rand_legal();
      2: g = 16'($urandom());
      default: begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 1) == 1) g[4*i +: 4] = s[4*int'($urandom_range(0, 3)) +: 4];
          else g[4*i +: 4] = 4'($urandom_range(0, 9));
        end
      end
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // One complete transaction with out_ready held high.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input string tag, input logic [15:0] s, input logic [15:0] g,
                         input logic p, input int eb, input int ec, input int ew,
                         input int ei, input int elat);
    int lat;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (in_ready) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, " in_ready"}, 0, 1);
      return;
    end
    in_secret = s;
    in_guess  = g;
    in_player = p;
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    lat  = -1;
    for (int e = 0; e < 20 && !seen; e++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1'b1;
        lat  = e + 1;
      end
    end
    check({tag, " latency"}, lat, elat);
    if (!seen) begin
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      return;
    end
    check({tag, " bulls"},   int'(out_bulls),   eb);
    check({tag, " cows"},    int'(out_cows),    ec);
    check({tag, " win"},     int'(out_win),     ew);
    check({tag, " invalid"}, int'(out_invalid), ei);
    check({tag, " player"},  int'(out_player),  int'(p));
    @(negedge clock);
    check({tag, " reported once"}, int'(out_valid), 0);
  endtask

  vec_t vecs[$];
  int   b, c, w, inv, lat, cnt;
  logic [15:0] rs, rg;
  logic        rp;

  initial begin
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 4, 0, 1, 0, 6});
    vecs.push_back('{16'h1234, 16'h4321, 1'b1, 0, 4, 0, 0, 6});
    vecs.push_back('{16'h1234, 16'h1243, 1'b0, 2, 2, 0, 0, 6});
    vecs.push_back('{16'h1234, 16'h5678, 1'b1, 0, 0, 0, 0, 6});
    vecs.push_back('{16'h1234, 16'h1123, 1'b0, 0, 0, 0, 1, 2});
    vecs.push_back('{16'h1234, 16'h12A4, 1'b1, 0, 0, 0, 1, 2});
    vecs.push_back('{16'h0987, 16'h0789, 1'b0, 2, 2, 0, 0, 6});
    vecs.push_back('{16'h1234, 16'h0000, 1'b0, 0, 0, 0, 1, 2});
`ifdef BC_SECRET_CHECK_EN
    vecs.push_back('{16'h1224, 16'h1234, 1'b1, 0, 0, 0, 1, 2});
`else
    vecs.push_back('{16'h1224, 16'h1234, 1'b1, 3, 0, 0, 0, 6});
`endif

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_player = 1'b0;
    in_secret = '0;
    in_guess  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset in_ready",    int'(in_ready),    1);
    check("reset out_valid",   int'(out_valid),   0);
    check("reset out_bulls",   int'(out_bulls),   0);
    check("reset out_cows",    int'(out_cows),    0);
    check("reset out_win",     int'(out_win),     0);
    check("reset out_invalid", int'(out_invalid), 0);
    check("reset out_player",  int'(out_player),  0);
    reset = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_txn($sformatf("vec%0d", i), vecs[i].secret, vecs[i].guess, vecs[i].player,
              vecs[i].bulls, vecs[i].cows, vecs[i].win, vecs[i].invalid, vecs[i].lat);
    end

    // Back-pressure: result held 5 cycles, extra in_valid ignored
    out_ready = 1'b0;
    @(negedge clock);
    in_secret = 16'h1234;
    in_guess  = 16'h1243;
    in_player = 1'b1;
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    check("hold reached done", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("hold stable %0d", k),
            int'({out_valid, in_ready, out_bulls, out_cows, out_invalid, out_player}),
            int'({1'b1, 1'b0, 3'd2, 3'd2, 1'b0, 1'b1}));
      if (k == 1) begin
        in_secret = 16'h5678;
        in_guess  = 16'h5678;
        in_player = 1'b0;
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("hold handshake out_valid", int'(out_valid), 0);
    check("hold handshake in_ready",  int'(in_ready),  1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (out_valid) cnt++;
    end
    check("ignored pulse produced no result", cnt, 0);

    // Reset abort at the 2nd COMPARE cycle
    @(negedge clock);
    in_secret = 16'h1234;
    in_guess  = 16'h1234;
    in_player = 1'b1;
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort in_ready",    int'(in_ready),    1);
    check("abort out_valid",   int'(out_valid),   0);
    check("abort out_bulls",   int'(out_bulls),   0);
    check("abort out_cows",    int'(out_cows),    0);
    check("abort out_win",     int'(out_win),     0);
    check("abort out_invalid", int'(out_invalid), 0);
    check("abort out_player",  int'(out_player),  0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (out_valid) cnt++;
    end
    check("abort no result", cnt, 0);

    // Random pairs against the rule model
    for (int n = 0; n < 40; n++) begin
      rs = ($urandom_range(0, 4) == 0) ? 16'($urandom()) : rand_legal();
      rg = rand_guess(rs);
      rp = 1'($urandom_range(0, 1));
      model(rs, rg, b, c, w, inv, lat);
      run_txn($sformatf("rnd%0d s=%h g=%h", n, rs, rg), rs, rg, rp, b, c, w, inv, lat);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_bc_scorer
